latch_bank_write_ctrl: RTL and testbench

//  Write controller and arbiter for a bank of NWORDS D-latch words (data/en latches).

---
 rtl/latch_ctrl_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/latch_bank_write_ctrl.sv | 98 +++++++++
 tb/tb_latch_bank_write_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch-bank write controller: FSM state encoding and
// the width of the enable-open down-counter.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int OPEN_CNT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (enable && !valid && req[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Arbitrated write sequencer for a bank of D-latch words: each write runs
// data-setup -> enable-open -> enable-closed hold so data brackets every en edge.
module latch_bank_write_ctrl #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int NWORDS   = 4,
  parameter int OPEN_CYC = 1,
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        lat_data,
  output logic [NWORDS-1:0]    lat_en,
  output logic                 busy
);

  import latch_ctrl_pkg::*;

  state_e                state;
  logic [OPEN_CNT_W-1:0] cnt;
  logic [AW-1:0]         addr_q;
  logic [PW-1:0]         rr_ptr;
  logic [NREQ-1:0]       arb_gnt;
  logic [PW-1:0]         arb_idx;
  logic                  arb_valid;

  // Out-of-range addresses decode to no enable, so the write is sequenced harmlessly.
  function automatic logic [NWORDS-1:0] word_sel(input logic [AW-1:0] a);
    logic [NWORDS-1:0] s;
    s = '0;
    for (int j = 0; j < NWORDS; j++)
      if (int'(a) == j) s[j] = 1'b1;
    return s;
  endfunction

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .enable (state == IDLE),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= '0;
      lat_en   <= '0;
      lat_data <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state    <= SETUP;
            busy     <= 1'b1;
            gnt      <= arb_gnt;
            addr_q   <= addr[arb_idx*AW +: AW];
            lat_data <= wdata[arb_idx*DW +: DW];
            rr_ptr   <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
          end
        end
        SETUP: begin
          state  <= OPEN;
          lat_en <= word_sel(addr_q);
          cnt    <= OPEN_CNT_W'(OPEN_CYC - 1);
        end
        OPEN: begin
          if (cnt == '0) begin
            state  <= HOLD;
            lat_en <= '0;
            done   <= gnt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: two instances (OPEN_CYC=1 and 3) share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_latch_bank_write_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int NW   = 4;
  localparam int AW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;

  logic [NREQ-1:0] gnt0, done0, gnt3, done3;
  logic [DW-1:0]   lat_data0, lat_data3;
  logic [NW-1:0]   lat_en0, lat_en3;
  logic            busy0, busy3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  latch_bank_write_ctrl #(.NREQ(NREQ), .DW(DW), .NWORDS(NW), .OPEN_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt0), .done(done0), .lat_data(lat_data0), .lat_en(lat_en0), .busy(busy0)
  );

  latch_bank_write_ctrl #(.NREQ(NREQ), .DW(DW), .NWORDS(NW), .OPEN_CYC(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .done(done3), .lat_data(lat_data3), .lat_en(lat_en3), .busy(busy3)
  );

  // Reference model: one in-flight transaction per instance, t = cycles since grant.
  int          oc     [2] = '{1, 3};
  bit          m_busy [2];
  int          m_t    [2];
  int          m_w    [2];
  int          m_addr [2];
  int          m_ptr  [2];
  logic [7:0]  m_data [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_t[d]    = 0;
        m_ptr[d]  = 0;
        m_data[d] = 8'h00;
      end else if (!m_busy[d]) begin
        for (int i = 0; i < NREQ; i++) begin
          int k;
          k = (m_ptr[d] + i) % NREQ;
          if (!m_busy[d] && req[k]) begin
            m_busy[d] = 1'b1;
            m_t[d]    = 1;
            m_w[d]    = k;
            m_addr[d] = int'(addr[k*AW +: AW]);
            m_data[d] = wdata[k*DW +: DW];
            m_ptr[d]  = (k + 1) % NREQ;
          end
        end
      end else begin
        m_t[d]++;
        if (m_t[d] == 3 + oc[d]) m_busy[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [3:0] eg, ee, ed;
      logic [3:0] og, oe, od;
      logic [7:0] odat;
      logic       ob;
      int         len;
      len = 3 + oc[d];
      eg  = m_busy[d] ? 4'(1 << m_w[d]) : 4'h0;
      ee  = (m_busy[d] && m_t[d] >= 2 && m_t[d] <= 1 + oc[d] && m_addr[d] < NW)
            ? 4'(1 << m_addr[d]) : 4'h0;
      ed  = (m_busy[d] && m_t[d] == len - 1) ? 4'(1 << m_w[d]) : 4'h0;
      og   = d ? gnt3 : gnt0;
      oe   = d ? lat_en3 : lat_en0;
      od   = d ? done3 : done0;
      odat = d ? lat_data3 : lat_data0;
      ob   = d ? busy3 : busy0;
      chk($sformatf("gnt[oc%0d]", oc[d]),      32'(og),   32'(eg));
      chk($sformatf("lat_en[oc%0d]", oc[d]),   32'(oe),   32'(ee));
      chk($sformatf("done[oc%0d]", oc[d]),     32'(od),   32'(ed));
      chk($sformatf("lat_data[oc%0d]", oc[d]), 32'(odat), 32'(m_data[d]));
      chk($sformatf("busy[oc%0d]", oc[d]),     32'(ob),   32'(m_busy[d]));
      chk($sformatf("lat_en_onehot[oc%0d]", oc[d]), 32'($countones(oe) <= 1), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int          en_cnt3;
    int          done_edge3;
    int          ng;
    int          g_idx [8];
    int          g_edge[8];
    logic [3:0]  prev_g;

    rst   = 1'b1;
    req   = '0;
    addr  = '0;
    wdata = '0;

    // Reset state
    do_reset();
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_lat_data", 32'(lat_data0), 32'd0);

    // Single request, word 2, A5
    req   = 4'b0001;
    addr  = 8'h02;
    wdata = 32'h0000_00A5;
    en_cnt3    = 0;
    done_edge3 = 0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 1) begin
        chk("t1_gnt_e1", 32'(gnt0), 32'h1);
        chk("t1_data_e1", 32'(lat_data0), 32'hA5);
        chk("t1_en_e1", 32'(lat_en0), 32'h0);
        req = 4'b0000;
      end
      if (e == 2) chk("t1_en_e2", 32'(lat_en0), 32'h4);
      if (e == 3) begin
        chk("t1_en_e3", 32'(lat_en0), 32'h0);
        chk("t1_done_e3", 32'(done0), 32'h1);
      end
      if (e == 4) begin
        chk("t1_busy_e4", 32'(busy0), 32'h0);
        chk("t1_gnt_e4", 32'(gnt0), 32'h0);
      end
      if (lat_en3 != '0) en_cnt3++;
      if (done3 != '0) done_edge3 = e;
      if (e == 6) chk("t6_busy_e6", 32'(busy3), 32'h0);
    end
    chk("t6_open_cycles", 32'(en_cnt3), 32'd3);
    chk("t6_done_edge", 32'(done_edge3), 32'd5);

    // All requesting from reset: order 0,1,2,3,0 four cycles apart
    do_reset();
    req    = 4'b1111;
    addr   = 8'b11_10_01_00;
    wdata  = 32'h44_33_22_11;
    ng     = 0;
    prev_g = '0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (gnt0 != '0 && prev_g == '0 && ng < 8) begin
        g_idx[ng]  = $clog2(gnt0);
        g_edge[ng] = e;
        ng++;
      end
      prev_g = gnt0;
    end
    req = '0;
    chk("t2_grant_count", 32'(ng >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_order_%0d", i), 32'(g_idx[i]), 32'(i % NREQ));
      chk($sformatf("t2_edge_%0d", i), 32'(g_edge[i]), 32'(1 + 4 * i));
    end

    // Requester 2 holds req (rr_ptr becomes 3), req1 rises and must win next
    do_reset();
    req   = 4'b0100;
    addr  = 8'h10;
    wdata = 32'h00_77_00_00;
    step();
    chk("t3_first_gnt", 32'(gnt0), 32'h4);
    req = 4'b0110;
    for (int e = 2; e <= 4; e++) step();
    step();
    chk("t3_req1_first", 32'(gnt0), 32'h2);
    req = '0;
    for (int e = 0; e < 8; e++) step();

    // Reset during OPEN
    do_reset();
    req   = 4'b0001;
    addr  = 8'h03;
    wdata = 32'h0000_0055;
    step();
    step();
    chk("t4_en_open", 32'(lat_en0), 32'h8);
    rst = 1'b1;
    req = 4'b0011;
    step();
    chk("t4_rst_en", 32'(lat_en0), 32'h0);
    chk("t4_rst_gnt", 32'(gnt0), 32'h0);
    chk("t4_rst_busy", 32'(busy0), 32'h0);
    chk("t4_rst_done", 32'(done0), 32'h0);
    rst = 1'b0;
    step();
    chk("t4_ptr_zero", 32'(gnt0), 32'h1);
    req = '0;
    for (int e = 0; e < 6; e++) step();

    // wdata changes after capture
    do_reset();
    req   = 4'b0001;
    addr  = 8'h01;
    wdata = 32'h0000_003C;
    step();
    wdata = 32'h0000_00FF;
    req   = '0;
    step();
    chk("t5_data_open", 32'(lat_data0), 32'h3C);
    step();
    chk("t5_data_hold", 32'(lat_data0), 32'h3C);
    for (int e = 0; e < 4; e++) step();
    chk("t5_data_oc3", 32'(lat_data3), 32'h3C);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(63) == 0);
      req   = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
      addr  = 8'($urandom);
      wdata = $urandom;
      step();
    end
    rst = 1'b0;
    req = '0;
    for (int e = 0; e < 8; e++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
